// File: rtl/iis_send_logic.sv
`default_nettype none
// ============================================================================
// Module      : iis_send_logic
// Description : I2S master transmitter. Buffers one 24-bit L/R pair behind a
//               valid/ready handshake, generates bclk/lrclk and shifts samples
//               out MSB-first in 32-bit slots. Optional macro
//               IIS_SEND_HOLD_LAST_EN repeats the last pair on underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module iis_send_logic #(
    parameter int BCLK_DIV = 16,
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic [DATA_W-1:0] ldata_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata_o,
    output logic              frame_start,
    output logic              underrun
);

    localparam int              c_DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int              c_CNT_W   = $clog2(2 * SLOT_W);
    localparam int              c_POS_W   = $clog2(SLOT_W);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(BCLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_bclk;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_hold_full;
    logic [DATA_W-1:0]  r_hold_l;
    logic [DATA_W-1:0]  r_hold_r;
    logic [DATA_W-1:0]  r_shift_l;
    logic [DATA_W-1:0]  r_shift_r;
    logic               r_frame_start;
    logic               r_underrun;

    logic               w_tick;
    logic               w_fall;
    logic               w_load;
    logic               w_in_ready;
    logic [c_CNT_W-1:0] w_k;
    logic [c_POS_W-1:0] w_pos;
    logic               w_right;
    logic [c_POS_W-1:0] w_bit_idx;
    logic               w_data_bit;

    assign w_tick     = (r_div_cnt == c_DIV_MAX);
    assign w_fall     = w_tick & r_bclk;
    assign w_k        = r_bit_cnt + c_CNT_W'(1);
    assign w_pos      = w_k[c_POS_W-1:0];
    assign w_right    = w_k[c_CNT_W-1];
    assign w_load     = w_fall & (w_k == '0);
    assign w_in_ready = rst & ~r_hold_full;

    // Slot position 1 carries the MSB; position 0 and the tail of the slot are zero padding.
    always_comb begin
        w_bit_idx  = '0;
        w_data_bit = 1'b0;
        if (w_pos >= c_POS_W'(1) && w_pos <= c_POS_W'(DATA_W)) begin
            w_bit_idx  = c_POS_W'(DATA_W) - w_pos;
            w_data_bit = w_right ? r_shift_r[w_bit_idx] : r_shift_l[w_bit_idx];
        end
    end

    always_ff @(posedge clk_100m) begin
        if (!rst) begin
            r_div_cnt     <= '0;
            r_bclk        <= 1'b0;
            r_bit_cnt     <= '1;
            r_lrclk       <= 1'b1;
            r_sdata       <= 1'b0;
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_shift_l     <= '0;
            r_shift_r     <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            if (w_tick) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end

            if (w_fall) begin
                r_bit_cnt <= w_k;
                r_lrclk   <= w_right;
                r_sdata   <= w_data_bit;
            end

            if (w_load) begin
                r_frame_start <= 1'b1;
                if (r_hold_full) begin
                    r_shift_l   <= r_hold_l;
                    r_shift_r   <= r_hold_r;
                    r_hold_full <= 1'b0;
                end else if (in_valid) begin
                    // Empty buffer and a pair arriving on the load edge: send it this frame.
                    r_shift_l <= ldata_i;
                    r_shift_r <= rdata_i;
                end else begin
                    r_underrun <= 1'b1;
`ifdef IIS_SEND_HOLD_LAST_EN
`else
                    r_shift_l  <= '0;
                    r_shift_r  <= '0;
`endif
                end
            end else if (in_valid && w_in_ready) begin
                r_hold_l    <= ldata_i;
                r_hold_r    <= rdata_i;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign bclk        = r_bclk;
    assign lrclk       = r_lrclk;
    assign sdata_o     = r_sdata;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: doc/iis_send_logic.md
Name: iis_send_logic

Overview:
- I2S master transmitter: the transmit counterpart of the I2S receive block in the audio path.
- Accepts 24-bit left/right sample pairs over a valid/ready handshake and buffers one pair.
- Generates bclk/lrclk from clk_100m and serialises samples MSB-first in standard I2S format (data delayed one bclk after the lrclk edge, 32-bit slots) to drive a DAC codec.

Parameters:
- BCLK_DIV, 16, bclk half-period in clk_100m cycles; legal range >= 2. Default gives bclk 3.125 MHz and lrclk about 48.8 kHz.
- DATA_W, 24, sample width; fixed at 24 for this revision.
- SLOT_W, 32, bclk periods per channel slot; fixed at 32.

Ports:
- clk_100m  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- ldata_i  input  24  left sample
- rdata_i  input  24  right sample
- in_valid  input  1  sample pair valid
- in_ready  output  1  = rst & !hold_full (combinational)
- bclk  output  1  bit clock, registered
- lrclk  output  1  word select, 0 = left, registered
- sdata_o  output  1  serial data, registered, changes with bclk falling
- frame_start  output  1  one-cycle pulse when a new frame is loaded
- underrun  output  1  one-cycle pulse: frame started with no data available

Behaviour:
- Reset values (rst low at a clk edge): div_cnt=0, bclk=0, bit_cnt=63, lrclk=1, sdata_o=0, hold_full=0, shift regs=0, frame_start=0, underrun=0. in_ready=0 while rst low.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps. bclk toggles on the cycle div_cnt==BCLK_DIV-1.
  - First bclk rise is BCLK_DIV cycles after reset release.
- fall_evt: the cycle where bclk toggles and bclk==1.
- On fall_evt, all of the following update on the same edge:
  - bit_cnt <= bit_cnt+1 (mod 64); call the new value k.
  - lrclk <= (k >= 32).
  - p = k mod 32. For p in 1..24, sdata_o <= channel bit (24-p), so the MSB is at p=1. For p = 0 or 25..31, sdata_o <= 0.
  - Channel is left for k < 32, right otherwise.
- Frame load on the fall_evt where k becomes 0:
  - If hold_full: shift regs <= hold pair, hold_full <= 0, frame_start=1.
  - Else if in_valid in the same cycle: bypass, incoming pair goes straight to shift regs, hold stays empty, frame_start=1, underrun=0.
  - Else: shift regs <= 0, frame_start=1, underrun=1.
- Accept: in_valid & in_ready stores the pair in hold and sets hold_full next cycle. Exception: bypass case above.
- While hold_full, in_ready=0; the source must hold data stable. in_ready returns to 1 the cycle after the frame load.
- Left slot transmits bits from the shift registers during bit_cnt 1..24; right slot during 33..56. Shift registers are not modified mid-frame.
- Reset mid-frame: all state returns to reset values on the next edge. Any in-flight and held samples are discarded, with no underrun pulse.
- Sampling by the codec: data is stable at bclk rising.

Optional Feature:
- Macro IIS_SEND_HOLD_LAST_EN.
  - Defined: on underrun, shift regs keep the previous frame, so the last pair repeats; underrun still pulses.
  - Undefined: on underrun, shift regs are zeroed and silence is sent.
  - No other behaviour differs.

Test Plan:
- Reset: hold rst=0 for 10 cycles, then release. Require bclk=0, lrclk=1, sdata_o=0, in_ready=0 during reset; in_ready=1 the first cycle after release; first bclk rise 16 cycles later; frame_start pulses at the first fall_evt (lrclk goes to 0).
- Data path: present ldata_i=24'hA5A5A5, rdata_i=24'h5A5A5C before the first frame. Sampling sdata_o at bclk rise must give:
  - left slot bits 1..24 = A5A5A5 MSB-first, bits 0 and 25..31 = 0;
  - right slot bits 33..56 = 5A5A5C;
  - lrclk period = 64 bclk = 2048 clk_100m cycles.
- Underrun: send one pair, then keep in_valid=0. The next frame start gives underrun=1 for one cycle and all-zero slots; with IIS_SEND_HOLD_LAST_EN defined, the previous pair repeats.
- Backpressure: drive in_valid=1 continuously with incrementing pairs (ldata 1, 2, 3...).
  - Pair 1 is accepted; in_ready stays 0 until the next frame load, and goes high one cycle after it.
  - Exactly one pair is accepted per frame, and consecutive frames carry consecutive values with none lost.
- Bypass: with hold empty, assert in_valid exactly on the frame-start cycle with ldata=24'h800001. The same frame transmits it, underrun=0, hold_full stays 0.
- Mid-frame reset: pull rst low at bit_cnt=10 of the left slot. Next edge: sdata_o=0, lrclk=1, bit_cnt=63; the held pair is discarded; after release the first frame underruns.
